riscv_multicycle_seq: RTL and testbench
=======================================

# riscv_multicycle_seq

Multi-cycle sequencer for the RV32I core. It steps the shared datapath through FETCH, DECODE, EXEC, MEM and WB, and holds the instruction register that feeds the decoder. It talks to instruction and data memories over a req/ready handshake, qualifies the decoder's write strobes so they fire only in the right phase, counts retired instructions, and traps on illegal opcodes or memory timeouts.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum wait cycles for a memory handshake. 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: enables the start of a new fetch.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: fetch complete; `imem_rdata` is valid.
- `imem_rdata` in 32: fetched instruction word.
- `ir` out `riscv_inst32_t`: instruction register, feeds the decoder.
- `mem_read` in 1: decoder load strobe.
- `mem_write` in 1: decoder store strobe.
- `reg_write` in 1: decoder register-write strobe.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a store.
- `dmem_ready` in 1: data access complete.
- `pc_we` out 1: PC update enable.
- `rf_we` out 1: register-file write enable, qualified by phase.
- `busy` out 1: sequencer is not in IDLE or TRAP.
- `err` out 2: sticky error code. 00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- `instret` out `CNT_W`: count of retired instructions.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. The reset state is IDLE.
- **IDLE:** go to FETCH when `run`=1.
- **FETCH:** `imem_req`=1.
  - When `imem_ready`=1, load `ir` with `imem_rdata` and go to DECODE.
- **DECODE:** single cycle.
  - Legal opcodes: LOAD, STORE, OP_IMM, OP, BRANCH, JAL, JALR, LUI, AUIPC.
  - Legal opcode: go to EXEC. Any other opcode: set `err`=01 and go to TRAP.
- **EXEC:** single cycle.
  - `mem_read` or `mem_write`: go to MEM.
  - Otherwise: go to WB.
- **MEM:** `dmem_req`=1, with `dmem_we` equal to `mem_write`.
  - Both outputs are held stable until `dmem_ready`=1, then go to WB.
- **WB:** single cycle.
  - `pc_we`=1 and `rf_we` equal to `reg_write`; `instret` increments, wrapping modulo 2^`CNT_W`.
  - Next state is FETCH if `run`=1, otherwise IDLE.
- **TRAP:** all request and write-enable outputs are 0. TRAP is left only by reset.
- **Timeout:**
  - A wait counter clears on entry to FETCH or MEM and increments each cycle the handshake is pending.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` with ready still 0, set `err` (10 in FETCH, 11 in MEM), drop the request and go to TRAP.
  - If ready arrives in the same cycle the counter reaches `TIMEOUT`, ready wins: no trap.
- **Write-enable rule:** `pc_we` and `rf_we` are never asserted outside WB, whatever the decoder strobes say.
- **Mid-run `run` drop:** `run`=0 does not abort an instruction in flight. It is sampled only in IDLE and WB.

## Timing
- Reset values:
  - `ir`=32'h0000_0013 (NOP).
  - `imem_req`, `dmem_req`, `dmem_we`, `pc_we`, `rf_we`, `busy` all 0.
  - `err`=00, `instret`=0.
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- Handshake:
  - A request asserts in the first cycle of its state.
  - Ready is sampled at the rising edge, and the transfer completes in the cycle where req and ready are both 1.
  - Ready may be high in the first request cycle, giving a zero-wait access.
- Latency with zero-wait memories, counted from FETCH entry to retirement:
  - ALU, branch or jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
  - Each memory wait cycle adds 1.
- `instret` updates on the clock edge that leaves WB.
- `err` updates on the edge that enters TRAP.
- Asynchronous reset mid-access:
  - Requests drop immediately and the FSM returns to IDLE.
  - `instret` and `err` clear.
  - An access in progress is abandoned; no retirement is counted.

## Structure
- Add to `riscv_package`:
  - `seq_state_t` enum.
  - `seq_err_t` 2-bit enum.
  - `NOP_INST` constant.
- Opcode constants already in the package are reused.
- One sub-module, `riscv_opcode_legal`: combinational check, `riscv_inst32_t` in, `legal` bit out. It is shared with future trap logic.

## Test plan
- **ALU retire:** reset, `run`=1, zero-wait imem returning 32'h0050_0093 (addi x1,x0,5). Required: `pc_we` and `rf_we` pulse in cycle 4; `instret`=1.
- **Load with wait:** imem returns 32'h0000_2103 (lw); `dmem_ready` asserts 3 cycles after `dmem_req`. Required: `dmem_req` held for 4 cycles with `dmem_we`=0; WB at cycle 8; `rf_we`=1.
- **Store:** imem returns 32'h0020_2023 (sw). Required: `dmem_we`=1 in MEM; `rf_we`=0 in WB; `instret` increments.
- **Illegal opcode:** imem returns 32'hFFFF_FFFF. Required: TRAP after DECODE; `err`=01; `busy`=0; no `pc_we`; `run` ignored until `rst_n` is pulsed.
- **imem timeout:** `TIMEOUT`=4, `imem_ready` held at 0. Required: TRAP and `err`=10 after 4 wait cycles. Repeat with ready arriving on the 4th cycle: no trap.
- **Async reset mid-MEM:** assert `rst_n`=0 during MEM. Required: `dmem_req`=0 immediately and `instret`=0. After release, with `run`=1, the FSM restarts at FETCH.

Source files
------------

// File: rtl/riscv_multicycle_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_package
// Brief    : Shared RV32I types, opcodes and sequencer state/error encodings.
// Revision : 1.0
// ============================================================================
package riscv_package;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } riscv_inst32_t;

    localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
    localparam logic [6:0] OPC_STORE    = 7'b010_0011;
    localparam logic [6:0] OPC_OP       = 7'b011_0011;
    localparam logic [6:0] OPC_LUI      = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
    localparam logic [6:0] OPC_JALR     = 7'b110_0111;
    localparam logic [6:0] OPC_JAL      = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

    // addi x0, x0, 0
    localparam riscv_inst32_t NOP_INST = riscv_inst32_t'(32'h0000_0013);

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_TRAP   = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        SEQ_ERR_NONE    = 2'b00,
        SEQ_ERR_ILLEGAL = 2'b01,
        SEQ_ERR_IMEM_TO = 2'b10,
        SEQ_ERR_DMEM_TO = 2'b11
    } seq_err_t;

endpackage
`default_nettype wire

// File: rtl/riscv_multicycle_seq_opcode_legal.sv
`default_nettype none
// ============================================================================
// Module   : riscv_opcode_legal
// Brief    : Flags whether an instruction carries an RV32I opcode the core runs.
// Revision : 1.0
// ============================================================================
module riscv_opcode_legal
    import riscv_package::*;
(
    input  riscv_inst32_t inst,
    output logic          legal
);

    // Only the opcode field matters; the rest is folded away to keep lint quiet.
    logic w_unused_fields;
    assign w_unused_fields = ^{inst.funct7, inst.rs2, inst.rs1, inst.funct3, inst.rd};

    always_comb begin
        legal = 1'b0;
        case (inst.opcode)
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multicycle_seq
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with IR and traps.
// Revision : 1.0
// ============================================================================
module riscv_multicycle_seq
    import riscv_package::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output riscv_inst32_t     ir,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              rf_we,
    output logic              busy,
    output logic [1:0]        err,
    output logic [CNT_W-1:0]  instret
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    seq_state_t         state_q, state_d;
    riscv_inst32_t      ir_q, ir_d;
    seq_err_t           err_q, err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               imem_req_q, imem_req_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic               pc_we_q, pc_we_d;
    logic               rf_we_q, rf_we_d;
    logic               busy_q, busy_d;

    logic w_legal;
    logic w_to_hit;

    riscv_opcode_legal u_opcode_legal (
        .inst  (ir_q),
        .legal (w_legal)
    );

    // True in the cycle whose still-pending handshake would be the TIMEOUT-th wait.
    assign w_to_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        err_d     = err_q;
        instret_d = instret_q;
        wait_d    = wait_q + 1'b1;

        case (state_q)
            SEQ_IDLE:   if (run) state_d = SEQ_FETCH;
            SEQ_FETCH: begin
                if (imem_ready) begin
                    ir_d    = riscv_inst32_t'(imem_rdata);
                    state_d = SEQ_DECODE;
                end else if (w_to_hit) begin
                    err_d   = SEQ_ERR_IMEM_TO;
                    state_d = SEQ_TRAP;
                end
            end
            SEQ_DECODE: begin
                if (w_legal) begin
                    state_d = SEQ_EXEC;
                end else begin
                    err_d   = SEQ_ERR_ILLEGAL;
                    state_d = SEQ_TRAP;
                end
            end
            SEQ_EXEC:   state_d = (mem_read || mem_write) ? SEQ_MEM : SEQ_WB;
            SEQ_MEM: begin
                if (dmem_ready) begin
                    state_d = SEQ_WB;
                end else if (w_to_hit) begin
                    err_d   = SEQ_ERR_DMEM_TO;
                    state_d = SEQ_TRAP;
                end
            end
            SEQ_WB: begin
                instret_d = instret_q + 1'b1;
                state_d   = run ? SEQ_FETCH : SEQ_IDLE;
            end
            SEQ_TRAP:   state_d = SEQ_TRAP;
            default:    state_d = SEQ_IDLE;
        endcase

        if (state_d != state_q) wait_d = '0;

        // Outputs are computed from the next state so each one is a plain flop.
        imem_req_d = (state_d == SEQ_FETCH);
        dmem_req_d = (state_d == SEQ_MEM);
        pc_we_d    = (state_d == SEQ_WB);
        rf_we_d    = (state_d == SEQ_WB) && reg_write;
        busy_d     = (state_d != SEQ_IDLE) && (state_d != SEQ_TRAP);
        if (state_d != SEQ_MEM)        dmem_we_d = 1'b0;
        else if (state_q == SEQ_EXEC)  dmem_we_d = mem_write;
        else                           dmem_we_d = dmem_we_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_IDLE;
            ir_q       <= NOP_INST;
            err_q      <= SEQ_ERR_NONE;
            instret_q  <= '0;
            wait_q     <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            pc_we_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            err_q      <= err_d;
            instret_q  <= instret_d;
            wait_q     <= wait_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            pc_we_q    <= pc_we_d;
            rf_we_q    <= rf_we_d;
            busy_q     <= busy_d;
        end
    end

    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign pc_we    = pc_we_q;
    assign rf_we    = rf_we_q;
    assign busy     = busy_q;
    assign ir       = ir_q;
    assign err      = err_q;
    assign instret  = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_multicycle_seq
// Brief    : Directed bench; per-cycle expectations come from an instruction-level model.
// Revision : 1.0
// ============================================================================
module tb_riscv_multicycle_seq;
    import riscv_package::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              run = 1'b0;
    logic              imem_ready = 1'b0;
    logic              dmem_ready = 1'b0;
    logic [31:0]       imem_rdata = 32'h0;
    logic              force_rw = 1'b0;
    riscv_inst32_t     ir;
    logic              mem_read, mem_write, reg_write;
    logic              imem_req, dmem_req, dmem_we, pc_we, rf_we, busy;
    logic [1:0]        err;
    logic [CNT_W-1:0]  instret;

    always #5 clk = ~clk;

    riscv_multicycle_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ir(ir), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .rf_we(rf_we), .busy(busy), .err(err), .instret(instret)
    );

    // Decoder stand-in; force_rw pins reg_write high to probe the write-enable gating.
    assign mem_read  = (ir.opcode == 7'h03);
    assign mem_write = (ir.opcode == 7'h23);
    assign reg_write = force_rw || !((ir.opcode == 7'h23) || (ir.opcode == 7'h63));

    typedef struct {
        logic        run, iready, dready;
        logic [31:0] rdata;
        logic [5:0]  outs;     // imem_req, dmem_req, dmem_we, pc_we, rf_we, busy
        logic [1:0]  err;
        logic [31:0] instret;
        logic [31:0] ir;
        string       tag;
    } row_t;

    row_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [1:0]  m_err = 2'b00;
    logic [31:0] m_instret = 32'd0;
    logic [31:0] m_ir = 32'h0000_0013;
    logic [31:0] alu_set [6] = '{32'h0000_006F, 32'h1234_50B7, 32'h0000_0063,
                                 32'h0000_0097, 32'h0000_80E7, 32'h0020_81B3};

    function automatic bit is_legal(input logic [6:0] op);
        case (op)
            7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic run_i, input logic ir_i, input logic dr_i,
                        input logic [31:0] rdata_i, input logic [5:0] outs_i);
        row_t r;
        r.tag = tag; r.run = run_i; r.iready = ir_i; r.dready = dr_i; r.rdata = rdata_i;
        r.outs = outs_i; r.err = m_err; r.instret = m_instret; r.ir = m_ir;
        q.push_back(r);
    endtask

    task automatic push_idle(input logic run_i);
        push("IDLE", run_i, 1'b0, 1'b0, 32'h0, 6'b000000);
    endtask

    task automatic push_trap();
        push("TRAP", 1'b1, 1'b1, 1'b1, 32'h0, 6'b000000);
    endtask

    // One instruction's cycle-by-cycle life, from FETCH entry to retirement or trap.
    task automatic push_instr(input logic [31:0] inst, input int iwait, input int dwait,
                              input logic mid_run, input logic wb_run, output int lat);
        logic [6:0] op;
        bit         st, mem, wr;
        op  = inst[6:0];
        st  = (op == 7'h23);
        mem = (op == 7'h03) || st;
        wr  = !(st || op == 7'h63) || force_rw;
        lat = 0;
        for (int i = 0; i <= iwait; i++) begin
            if (TIMEOUT != 0 && i == TIMEOUT) begin m_err = 2'b10; return; end
            push("FETCH", mid_run, i == iwait, 1'b0, (i == iwait) ? inst : 32'hDEAD_BEEF, 6'b100001);
            lat++;
        end
        m_ir = inst;
        push("DECODE", mid_run, 1'b0, 1'b0, 32'h0, 6'b000001); lat++;
        if (!is_legal(op)) begin m_err = 2'b01; return; end
        push("EXEC", mid_run, 1'b0, 1'b0, 32'h0, 6'b000001); lat++;
        if (mem) begin
            for (int j = 0; j <= dwait; j++) begin
                if (TIMEOUT != 0 && j == TIMEOUT) begin m_err = 2'b11; return; end
                push("MEM", mid_run, 1'b0, j == dwait, 32'h0, {2'b01, st, 3'b001});
                lat++;
            end
        end
        push("WB", wb_run, 1'b0, 1'b0, 32'h0, {3'b000, 1'b1, wr, 1'b1}); lat++;
        m_instret++;
    endtask

    task automatic play(input bit stop_at_mem);
        while (q.size() > 0) begin
            row_t r;
            r = q.pop_front();
            @(posedge clk); #1;
            n_vec++;
            if ({imem_req, dmem_req, dmem_we, pc_we, rf_we, busy, err, instret, ir} !==
                {r.outs, r.err, r.instret, r.ir}) begin
                n_bad++;
                $display("FAIL %s @%0t: got req/dreq/we/pcwe/rfwe/busy=%b err=%b instret=%0d ir=%h, want %b %b %0d %h",
                         r.tag, $time, {imem_req, dmem_req, dmem_we, pc_we, rf_we, busy}, err, instret, ir,
                         r.outs, r.err, r.instret, r.ir);
            end
            run = r.run; imem_ready = r.iready; dmem_ready = r.dready; imem_rdata = r.rdata;
            if (stop_at_mem && r.outs[4]) begin q.delete(); break; end
        end
    endtask

    task automatic model_reset();
        m_err = 2'b00; m_instret = 32'd0; m_ir = 32'h0000_0013;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        model_reset();
        chk("rst_outs", {26'd0, imem_req, dmem_req, dmem_we, pc_we, rf_we, busy}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_ir", ir, 32'h0000_0013);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        do_reset();

        push_idle(1'b1);
        push_instr(32'h0050_0093, 0, 0, 1'b1, 1'b0, lat);
        chk("alu_latency", lat, 32'd4);
        push_idle(1'b0); push_idle(1'b0);
        play(1'b0);
        chk("alu_instret", instret, 32'd1);
        chk("alu_ir", ir, 32'h0050_0093);

        // lw with 3 dmem waits and run dropped mid-flight, then sw with one imem wait
        push_idle(1'b1);
        push_instr(32'h0000_2103, 0, 3, 1'b0, 1'b1, lat);
        chk("lw_latency", lat, 32'd8);
        push_instr(32'h0020_2023, 1, 0, 1'b0, 1'b0, lat);
        chk("sw_latency", lat, 32'd6);
        push_idle(1'b0);
        play(1'b0);
        chk("ldst_instret", instret, 32'd3);

        push_idle(1'b1);
        for (int i = 0; i < 6; i++) push_instr(alu_set[i], 0, 0, 1'b1, i != 5, lat);
        push_idle(1'b0);
        play(1'b0);
        chk("mix_instret", instret, 32'd9);

        force_rw = 1'b1;
        push_idle(1'b1);
        push_instr(32'hFFFF_FFFF, 0, 0, 1'b1, 1'b1, lat);
        repeat (4) push_trap();
        play(1'b0);
        chk("illegal_err", {30'd0, err}, 32'd1);
        force_rw = 1'b0;
        do_reset();

        push_idle(1'b1);
        push_instr(32'h0050_0093, 9, 0, 1'b1, 1'b1, lat);
        repeat (3) push_trap();
        play(1'b0);
        chk("imem_to_err", {30'd0, err}, 32'd2);
        do_reset();

        push_idle(1'b1);
        push_instr(32'h0050_0093, 3, 0, 1'b1, 1'b0, lat);
        chk("imem_edge_latency", lat, 32'd7);
        push_idle(1'b0);
        play(1'b0);
        chk("imem_edge_instret", instret, 32'd1);

        push_idle(1'b1);
        push_instr(32'h0000_2103, 0, 6, 1'b1, 1'b1, lat);
        repeat (3) push_trap();
        play(1'b0);
        chk("dmem_to_err", {30'd0, err}, 32'd3);
        do_reset();

        // Asynchronous reset in the first MEM cycle, after one retirement
        push_idle(1'b1);
        push_instr(32'h0050_0093, 0, 0, 1'b1, 1'b1, lat);
        push_instr(32'h0000_2103, 0, 2, 1'b1, 1'b1, lat);
        play(1'b1);
        chk("pre_rst_instret", instret, 32'd1);
        #2;
        rst_n = 1'b0; run = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("async_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("async_instret", instret, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(1'b1);
        push_instr(32'h0050_0093, 0, 0, 1'b1, 1'b0, lat);
        push_idle(1'b0);
        play(1'b0);
        chk("restart_instret", instret, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
